spc_stack: RTL and testbench
============================

Name: spc_stack

Overview:
Parametrised successor to the SPC return-address stack. It provides a micro-PC stack of configurable width and depth with a registered top-of-stack output and push, pop and replace operations gated by state_fetch. It adds occupancy tracking, full/empty status, selectable wrap or saturate mode, and sticky overflow/underflow error flags. It sits beside the micro-sequencer and feeds the return address to the next-PC mux.

Parameters:
DATA_WIDTH, 19, width of each stack entry (micro-PC plus flag bits)
ADDR_WIDTH, 5, log2 of stack depth; DEPTH = 2**ADDR_WIDTH
WRAP, 1, 1 = circular pointer (legacy behaviour, oldest entry silently lost); 0 = saturating, out-of-range operations are suppressed

Ports:
clk  input  1  system clock, all state updates on the rising edge
reset_n  input  1  asynchronous active-low reset
state_fetch  input  1  operation strobe; push/pop are ignored when low
push  input  1  push wdata (when qualified by state_fetch)
pop  input  1  pop top entry (when qualified by state_fetch)
wdata  input  DATA_WIDTH  data to push or replace
err_clr  input  1  clear sticky ovf/unf
rdata  output  DATA_WIDTH  registered top-of-stack
ptr  output  ADDR_WIDTH  current top pointer
count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH
empty  output  1  count == 0, combinational from count
full  output  1  count == DEPTH, combinational from count
ovf  output  1  sticky overflow
unf  output  1  sticky underflow

Behaviour:
- Clock and reset: single clock domain, clk. reset_n is asynchronous and active-low. While reset is asserted: ptr=0, count=0, rdata=0, ovf=0, unf=0. Memory contents are not reset. Reset released mid-sequence discards all stack state.
- Operation qualifier: op = {push,pop} & {2{state_fetch}}. With op=00, nothing changes and rdata holds.
- Push (10):
  - Write mem[ptr+1] = wdata; ptr += 1 (mod DEPTH); count += 1.
  - When full and WRAP=1: write and ptr update still occur; count stays DEPTH; ovf set.
  - When full and WRAP=0: no write, no ptr change; ovf set.
- Pop (01):
  - ptr -= 1 (mod DEPTH); count -= 1.
  - When empty and WRAP=1: ptr still decrements; count stays 0; unf set.
  - When empty and WRAP=0: no change; unf set.
- Replace (11): write mem[ptr] = wdata; ptr and count unchanged. When empty: write still occurs; count stays 0; no flag set.
- rdata:
  - Updated on every qualified op. Next-cycle value = mem[ptr_next] as seen after this cycle's write (read-new-data).
  - After a push or replace, rdata equals wdata on the following cycle. This must be a bypass mux, never a RAM read-during-write race.
  - After a pop, rdata equals the older entry.
  - rdata is meaningful only when !empty. When empty it holds its last value.
- Latency: rdata, ptr, count and flags are all valid 1 cycle after the qualifying edge.
- err_clr: clears ovf and unf on the next edge. If a new error occurs in the same cycle, setting wins.
- Arithmetic: ptr arithmetic is modulo 2**ADDR_WIDTH. count never exceeds DEPTH and never goes below 0.

Decomposition:
- Package spc_pkg:
  - op encoding localparams: OP_NONE, OP_POP, OP_PUSH, OP_REPL
  - default widths: SPC_DATA_WIDTH=19, SPC_ADDR_WIDTH=5
- Sub-module spc_ram: simple dual-port RAM with one synchronous write port and one synchronous read port, no reset, so it infers block RAM. Parametrised DATA_WIDTH/ADDR_WIDTH.
- spc_stack contains the pointer/count/flag logic and the write-through bypass register.

Test Plan:
- Reset, then push 19'h00123 and 19'h00456 with state_fetch=1 → next cycles rdata=00123 then 00456; ptr=2; count=2. Pop → rdata=00123, ptr=1, count=1.
- Push with state_fetch=0 → ptr, count and rdata unchanged; memory not written (a later pop shows the old contents).
- Replace with count=1, wdata=19'h7FFFF → rdata=7FFFF; ptr and count unchanged.
- WRAP=1: 33 pushes of values 1..33 → count=32, ovf=1. 32 pops then return 33 down to 2. A further pop → unf=1, count=0. err_clr → both flags 0.
- WRAP=0: 33 pushes → 33rd push ignored, ovf=1, rdata=32. Pop from empty → ptr unchanged, unf=1. err_clr in the same cycle as a new pop-empty → unf stays 1.
- Assert reset_n low asynchronously between edges during a push burst → ptr, count and rdata are 0 immediately. After release, the first push lands at mem[1].

Source files
------------

// File: rtl/spc_pkg.sv
// spc_pkg: shared op encodings and default widths for the micro-PC return stack
package spc_pkg;
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;
    localparam int SPC_DATA_WIDTH = 19;
    localparam int SPC_ADDR_WIDTH = 5;
endpackage

// File: rtl/spc_stack_if.sv
// spc_stack_if: sequencer-side command and status bundle of the return stack
interface spc_stack_if
    import spc_pkg::*;
#(
    parameter int DATA_WIDTH = SPC_DATA_WIDTH,
    parameter int ADDR_WIDTH = SPC_ADDR_WIDTH
);
    logic                  state_fetch;
    logic                  push;
    logic                  pop;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  ovf;
    logic                  unf;
    modport master (
        output state_fetch, push, pop, err_clr, wdata,
        input  rdata, ptr, count, empty, full, ovf, unf
    );
    modport slave (
        input  state_fetch, push, pop, err_clr, wdata,
        output rdata, ptr, count, empty, full, ovf, unf
    );
endinterface

// File: rtl/spc_ram.sv
// spc_ram: simple dual-port RAM, sync write, sync read with enable, no reset
module spc_ram #(
    parameter int DATA_WIDTH = 19,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/spc_stack.sv
// spc_stack: micro-PC return stack with occupancy, wrap/saturate mode and sticky errors
module spc_stack
    import spc_pkg::*;
#(
    parameter int DATA_WIDTH = SPC_DATA_WIDTH,
    parameter int ADDR_WIDTH = SPC_ADDR_WIDTH,
    parameter bit WRAP       = 1'b1
) (
    input logic        clk,
    input logic        reset_n,
    spc_stack_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);
    logic [1:0]            w_op;
    logic                  w_push, w_pop, w_repl, w_full, w_empty;
    logic                  w_push_ok, w_pop_ok, w_we, w_re;
    logic [ADDR_WIDTH-1:0] w_ptr_inc, w_ptr_dec, w_ptr_nxt, w_waddr;
    logic [CW-1:0]         w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_ram_q;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [CW-1:0]         r_cnt;
    logic                  r_ovf, r_unf, r_byp_sel;
    logic [DATA_WIDTH-1:0] r_byp;
    always_comb begin
        w_op      = {bus.push, bus.pop} & {2{bus.state_fetch}};
        w_push    = w_op == OP_PUSH;
        w_pop     = w_op == OP_POP;
        w_repl    = w_op == OP_REPL;
        w_full    = r_cnt == DEPTH;
        w_empty   = r_cnt == '0;
        w_push_ok = w_push && (!w_full || WRAP);
        w_pop_ok  = w_pop && (!w_empty || WRAP);
        w_ptr_inc = r_ptr + 1'b1;
        w_ptr_dec = r_ptr - 1'b1;
        w_ptr_nxt = w_push_ok ? w_ptr_inc : w_pop_ok ? w_ptr_dec : r_ptr;
        w_cnt_nxt = (w_push && !w_full) ? r_cnt + 1'b1 : (w_pop && !w_empty) ? r_cnt - 1'b1 : r_cnt;
        w_we      = w_push_ok || w_repl;
        w_waddr   = w_repl ? r_ptr : w_ptr_inc;
        w_re      = w_op != OP_NONE && !(w_pop && w_empty);
    end
    // Every write targets w_ptr_nxt, so a write always forces the bypass path.
    spc_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (bus.wdata),
        .i_re    (w_re),
        .i_raddr (w_ptr_nxt),
        .o_rdata (w_ram_q)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_byp_sel <= 1'b1;
            r_byp     <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= (w_push && w_full) || (r_ovf && !bus.err_clr);
            r_unf <= (w_pop && w_empty) || (r_unf && !bus.err_clr);
            if (w_re) r_byp_sel <= w_we;
            if (w_we) r_byp <= bus.wdata;
        end
    end
    assign bus.rdata = r_byp_sel ? r_byp : w_ram_q;
    assign bus.ptr   = r_ptr;
    assign bus.count = r_cnt;
    assign bus.empty = w_empty;
    assign bus.full  = w_full;
    assign bus.ovf   = r_ovf;
    assign bus.unf   = r_unf;
endmodule

// File: tb/tb_spc_stack.sv
// tb_spc_stack: directed vectors and corner sequences for wrap and saturate stacks
module tb_spc_stack;
    localparam int DW = 19;
    localparam int AW = 5;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    spc_stack_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bw ();
    spc_stack_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bs ();
    spc_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRAP(1'b1)) dut_w (.clk(clk), .reset_n(reset_n), .bus(bw));
    spc_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRAP(1'b0)) dut_s (.clk(clk), .reset_n(reset_n), .bus(bs));
    int n_run = 0;
    int n_fail = 0;
    typedef struct {
        logic          sf, pu, po, clr;
        logic [DW-1:0] wd, rd;
        logic [AW-1:0] p;
        logic [AW:0]   c;
        logic [3:0]    fl;
    } vec_t;
    vec_t tv [11];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic setw(input logic sf, pu, po, clr, input logic [DW-1:0] wd);
        bw.state_fetch = sf; bw.push = pu; bw.pop = po; bw.err_clr = clr; bw.wdata = wd;
    endtask
    task automatic sets(input logic sf, pu, po, clr, input logic [DW-1:0] wd);
        bs.state_fetch = sf; bs.push = pu; bs.pop = po; bs.err_clr = clr; bs.wdata = wd;
    endtask
    // flags are {empty, full, ovf, unf}
    task automatic chk_all(input bit s, input string nm, input logic [DW-1:0] rd,
                           input logic [AW-1:0] p, input logic [AW:0] c, input logic [3:0] fl);
        chk({nm, ".rdata"}, s ? bs.rdata : bw.rdata, rd);
        chk({nm, ".ptr"},   s ? bs.ptr : bw.ptr, p);
        chk({nm, ".count"}, s ? bs.count : bw.count, c);
        chk({nm, ".flags"}, s ? {bs.empty, bs.full, bs.ovf, bs.unf} : {bw.empty, bw.full, bw.ovf, bw.unf}, fl);
    endtask
    initial begin
        tv[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h11111, 19'h11111, 5'd0, 6'd0, 4'b1000};
        tv[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 19'h00123, 19'h00123, 5'd1, 6'd1, 4'b0000};
        tv[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 19'h00456, 19'h00456, 5'd2, 6'd2, 4'b0000};
        tv[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 19'h0ABCD, 19'h00456, 5'd2, 6'd2, 4'b0000};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 19'h00000, 19'h00123, 5'd1, 6'd1, 4'b0000};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 19'h00000, 19'h00123, 5'd1, 6'd1, 4'b0000};
        tv[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 19'h7FFFF, 19'h7FFFF, 5'd1, 6'd1, 4'b0000};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 19'h00AAA, 19'h00AAA, 5'd2, 6'd2, 4'b0000};
        tv[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 19'h00000, 19'h7FFFF, 5'd1, 6'd1, 4'b0000};
        tv[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 19'h00000, 19'h11111, 5'd0, 6'd0, 4'b1000};
        tv[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 19'h00000, 19'h11111, 5'd0, 6'd0, 4'b1000};
        setw(0, 0, 0, 0, '0);
        sets(0, 0, 0, 0, '0);
        repeat (2) step();
        chk_all(0, "reset_w", '0, '0, '0, 4'b1000);
        chk_all(1, "reset_s", '0, '0, '0, 4'b1000);
        #2 reset_n = 1'b1;
        step();
        for (int i = 0; i < 11; i++) begin
            setw(tv[i].sf, tv[i].pu, tv[i].po, tv[i].clr, tv[i].wd);
            step();
            chk_all(0, $sformatf("vec%0d", i), tv[i].rd, tv[i].p, tv[i].c, tv[i].fl);
        end
        setw(0, 0, 0, 0, '0);
        for (int i = 1; i <= 33; i++) begin
            setw(1, 1, 0, 0, DW'(i));
            step();
        end
        setw(0, 0, 0, 0, '0);
        chk_all(0, "wrap_full", 19'd33, 5'd1, 6'd32, 4'b0110);
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("wrap_top%0d", i), bw.rdata, 32'(34 - i));
            setw(1, 0, 1, 0, '0);
            step();
        end
        setw(0, 0, 0, 0, '0);
        chk_all(0, "wrap_drained", 19'd33, 5'd1, 6'd0, 4'b1010);
        setw(1, 0, 1, 0, '0);
        step();
        setw(0, 0, 0, 0, '0);
        chk("wrap_unf.ptr", bw.ptr, 32'd0);
        chk("wrap_unf.count", bw.count, 32'd0);
        chk("wrap_unf.flags", {bw.empty, bw.full, bw.ovf, bw.unf}, 32'b1011);
        setw(0, 0, 0, 1, '0);
        step();
        setw(0, 0, 0, 0, '0);
        chk("wrap_clr.flags", {bw.empty, bw.full, bw.ovf, bw.unf}, 32'b1000);
        for (int i = 1; i <= 33; i++) begin
            sets(1, 1, 0, 0, DW'(i));
            step();
        end
        sets(0, 0, 0, 0, '0);
        chk_all(1, "sat_full", 19'd32, 5'd0, 6'd32, 4'b0110);
        for (int i = 1; i <= 32; i++) begin
            chk($sformatf("sat_top%0d", i), bs.rdata, 32'(33 - i));
            sets(1, 0, 1, 0, '0);
            step();
        end
        sets(0, 0, 0, 0, '0);
        chk_all(1, "sat_drained", 19'd32, 5'd0, 6'd0, 4'b1010);
        sets(1, 0, 1, 0, '0);
        step();
        chk_all(1, "sat_unf", 19'd32, 5'd0, 6'd0, 4'b1011);
        sets(0, 0, 0, 1, '0);
        step();
        chk_all(1, "sat_clr", 19'd32, 5'd0, 6'd0, 4'b1000);
        sets(1, 0, 1, 1, '0);
        step();
        sets(0, 0, 0, 0, '0);
        chk_all(1, "sat_clr_vs_unf", 19'd32, 5'd0, 6'd0, 4'b1001);
        setw(1, 1, 0, 0, 19'h000A1);
        step();
        chk_all(0, "burst1", 19'h000A1, 5'd1, 6'd1, 4'b0000);
        setw(1, 1, 0, 0, 19'h000A2);
        step();
        chk_all(0, "burst2", 19'h000A2, 5'd2, 6'd2, 4'b0000);
        setw(1, 1, 0, 0, 19'h000A3);
        #3 reset_n = 1'b0;
        #1;
        chk_all(0, "async_rst", '0, '0, '0, 4'b1000);
        setw(0, 0, 0, 0, '0);
        #2 reset_n = 1'b1;
        step();
        chk_all(0, "post_rst", '0, '0, '0, 4'b1000);
        setw(1, 1, 0, 0, 19'h0BEEF);
        step();
        chk_all(0, "post_push1", 19'h0BEEF, 5'd1, 6'd1, 4'b0000);
        setw(1, 1, 0, 0, 19'h0CAFE);
        step();
        chk_all(0, "post_push2", 19'h0CAFE, 5'd2, 6'd2, 4'b0000);
        setw(1, 0, 1, 0, '0);
        step();
        setw(0, 0, 0, 0, '0);
        chk_all(0, "post_pop", 19'h0BEEF, 5'd1, 6'd1, 4'b0000);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
